// File: rtl/mux_skid_n.sv
// N-way select stage: registered output plus one skid entry; one cycle from accept to out_valid.
// Stalls by dropping in_ready once the skid entry is occupied, so in_ready never depends on out_ready.
module mux_skid_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  // Occupancy is carried entirely by the two valid bits: {skid, main}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b11
  } state_t;

  logic [WIDTH-1:0] main_dat_q, main_dat_d;
  logic [SEL_W-1:0] main_sel_q, main_sel_d;
  logic             main_vld_q, main_vld_d;
  logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
  logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
  logic             skid_vld_q, skid_vld_d;

  logic [NUM_IN-1:0] sel_hit;
  logic [WIDTH-1:0]  sel_dat;
  logic              accept;
  logic              pop;
  state_t            state;

  // Out-of-range sel simply matches no channel, so nothing is accepted.
  always_comb begin
    sel_hit = '0;
    sel_dat = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel == SEL_W'(i)) begin
        sel_hit[i] = 1'b1;
        sel_dat    = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (rst_n && !flush && !skid_vld_q) begin
      in_ready = sel_hit;
    end
  end

  assign accept = |(in_valid & in_ready);
  assign pop    = main_vld_q & out_ready;
  assign state  = state_t'({skid_vld_q, main_vld_q});

  always_comb begin
    main_dat_d = main_dat_q;
    main_sel_d = main_sel_q;
    main_vld_d = main_vld_q;
    skid_dat_d = skid_dat_q;
    skid_sel_d = skid_sel_q;
    skid_vld_d = skid_vld_q;
    case (state)
      EMPTY: begin
        if (accept) begin
          main_dat_d = sel_dat;
          main_sel_d = sel;
          main_vld_d = 1'b1;
        end
      end
      ONE: begin
        if (accept && pop) begin
          main_dat_d = sel_dat;
          main_sel_d = sel;
        end else if (accept) begin
          skid_dat_d = sel_dat;
          skid_sel_d = sel;
          skid_vld_d = 1'b1;
        end else if (pop) begin
          main_vld_d = 1'b0;
        end
      end
      TWO: begin
        if (pop) begin
          main_dat_d = skid_dat_q;
          main_sel_d = skid_sel_q;
          skid_vld_d = 1'b0;
        end
      end
      default: begin
        main_vld_d = 1'b0;
        skid_vld_d = 1'b0;
      end
    endcase
    // Flush only clears valids; payload registers may keep stale contents.
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_dat_q <= '0;
      main_sel_q <= '0;
      main_vld_q <= 1'b0;
      skid_dat_q <= '0;
      skid_sel_q <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      main_dat_q <= main_dat_d;
      main_sel_q <= main_sel_d;
      main_vld_q <= main_vld_d;
      skid_dat_q <= skid_dat_d;
      skid_sel_q <= skid_sel_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  assign out_data  = main_dat_q;
  assign out_sel   = main_sel_q;
  assign out_valid = main_vld_q;

endmodule

// File: tb/tb_mux_skid_n.sv
// Scoreboard bench for mux_skid_n: a queue of accepted beats predicts ready, valid, data and tag.
module tb_mux_skid_n;
  localparam int W = 32;
  localparam int N = 4;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   s;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N*W-1:0] in_data;
  logic [N-1:0] in_valid;
  logic [N-1:0] in_ready;
  logic [1:0]   sel;
  logic         flush;
  logic [W-1:0] out_data;
  logic         out_valid;
  logic [1:0]   out_sel;
  logic         out_ready;

  logic [3*W-1:0] in_data3;
  logic [2:0]     in_valid3;
  logic [2:0]     in_ready3;
  logic [1:0]     sel3;
  logic [W-1:0]   out_data3;
  logic           out_valid3;
  logic [1:0]     out_sel3;

  int    n_vec = 0;
  int    n_err = 0;
  beat_t q[$];

  always #5 clk = ~clk;

  mux_skid_n #(.WIDTH(W), .NUM_IN(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .flush(flush), .out_data(out_data),
    .out_valid(out_valid), .out_sel(out_sel), .out_ready(out_ready)
  );

  mux_skid_n #(.WIDTH(W), .NUM_IN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data3), .in_valid(in_valid3),
    .in_ready(in_ready3), .sel(sel3), .flush(1'b0), .out_data(out_data3),
    .out_valid(out_valid3), .out_sel(out_sel3), .out_ready(1'b1)
  );

  function automatic logic [N-1:0] exp_rdy();
    if (rst_n && !flush && q.size() < 2) return 4'b0001 << sel;
    return '0;
  endfunction

  // Advance one edge, updating the model from the values the bench drove.
  task automatic step();
    logic acc;
    logic pp;
    beat_t b;
    @(posedge clk);
    acc = exp_rdy()[sel] & in_valid[sel];
    pp  = (q.size() != 0) && out_ready;
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) begin
        b.d = in_data[sel*W +: W];
        b.s = sel;
        q.push_back(b);
      end
    end
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [W-1:0] v);
    in_data[ch*W +: W] = v;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = '1; sel = 2'd1; flush = 1'b0; out_ready = 1'b1;
    in_data = '0; in_valid3 = '0; sel3 = '0; in_data3 = '0;
    step(); step();
    @(negedge clk);
    n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL reset_in_ready got=%b exp=0000", in_ready); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_vec++; if (out_data !== '0 || out_sel !== 2'd0) begin n_err++; $display("FAIL reset_out_data got=%h/%0d exp=0/0", out_data, out_sel); end
    in_valid = '0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    sel = 2'd2; in_valid = 4'b0100; set_ch(2, 32'hA5A5_0002); out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_vec++; if (in_ready !== 4'b0100) begin n_err++; $display("FAIL single_rdy c=%0d got=%b exp=0100", c, in_ready); end
      if (c == 1) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0002 || out_sel !== 2'd2) begin
          n_err++; $display("FAIL single_out got=%b/%h/%0d exp=1/a5a50002/2", out_valid, out_data, out_sel);
        end
      end
      if (c == 0) begin
        step(); in_valid = '0;
      end else begin
        step();
      end
    end
  endtask

  task automatic test_stream();
    sel = 2'd1; out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c < 8) ? 4'b0010 : 4'b0000;
      set_ch(1, W'(c + 1));
      @(negedge clk);
      n_vec++; if (in_ready !== exp_rdy()) begin n_err++; $display("FAIL stream_rdy c=%0d got=%b exp=%b", c, in_ready, exp_rdy()); end
      if (c >= 1 && c <= 8) begin
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== W'(c)) begin
          n_err++; $display("FAIL stream_out c=%0d got=%b/%0d exp=1/%0d", c, out_valid, out_data, c);
        end
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] rdy_plan [7] = '{4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b1000};
    logic [N-1:0] vld_plan [7] = '{4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic         ord_plan [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0]   sel_plan [7] = '{2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
    set_ch(0, 32'h10); set_ch(3, 32'h33);
    for (int c = 0; c < 7; c++) begin
      sel = sel_plan[c]; in_valid = vld_plan[c]; out_ready = ord_plan[c];
      @(negedge clk);
      n_vec++; if (in_ready !== rdy_plan[c]) begin n_err++; $display("FAIL bp_rdy c=%0d got=%b exp=%b", c, in_ready, rdy_plan[c]); end
      n_vec++; if (out_valid !== (q.size() != 0)) begin n_err++; $display("FAIL bp_vld c=%0d got=%b exp=%b", c, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        n_vec++;
        if (out_data !== q[0].d || out_sel !== q[0].s) begin
          n_err++; $display("FAIL bp_out c=%0d got=%h/%0d exp=%h/%0d", c, out_data, out_sel, q[0].d, q[0].s);
        end
      end
      step();
    end
  endtask

  task automatic fill_two();
    out_ready = 1'b0; sel = 2'd0; in_valid = 4'b0001; set_ch(0, 32'hC0);
    step();
    sel = 2'd2; in_valid = 4'b0100; set_ch(2, 32'hC2);
    step();
    in_valid = '0;
  endtask

  task automatic test_flush();
    fill_two();
    flush = 1'b1; in_valid = '1; sel = 2'd1;
    @(negedge clk);
    n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL flush_rdy got=%b exp=0000", in_ready); end
    step();
    flush = 1'b0; in_valid = '0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_vld got=%b exp=0", out_valid); end
    sel = 2'd1; in_valid = 4'b0010; set_ch(1, 32'hF1); out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (in_ready !== 4'b0010) begin n_err++; $display("FAIL flush_resume_rdy got=%b exp=0010", in_ready); end
    step();
    in_valid = '0;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_data !== 32'hF1 || out_sel !== 2'd1) begin
      n_err++; $display("FAIL flush_resume_out got=%b/%h/%0d exp=1/f1/1", out_valid, out_data, out_sel);
    end
    step();
  endtask

  task automatic test_reset_mid();
    fill_two();
    rst_n = 1'b0; in_valid = '1; out_ready = 1'b0;
    @(negedge clk);
    n_vec++; if (in_ready !== 4'b0000) begin n_err++; $display("FAIL rstmid_rdy got=%b exp=0000", in_ready); end
    step();
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b0 || out_data !== '0 || out_sel !== 2'd0) begin
      n_err++; $display("FAIL rstmid_out got=%b/%h/%0d exp=0/0/0", out_valid, out_data, out_sel);
    end
    rst_n = 1'b1; sel = 2'd3; in_valid = 4'b1000; set_ch(3, 32'h3E);
    @(negedge clk);
    n_vec++; if (in_ready !== 4'b1000) begin n_err++; $display("FAIL rstmid_resume_rdy got=%b exp=1000", in_ready); end
    step();
    in_valid = '0; out_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (out_valid !== 1'b1 || out_data !== 32'h3E || out_sel !== 2'd3) begin
      n_err++; $display("FAIL rstmid_resume_out got=%b/%h/%0d exp=1/3e/3", out_valid, out_data, out_sel);
    end
    step();
  endtask

  task automatic test_three();
    sel3 = 2'd3; in_valid3 = 3'b111;
    in_data3 = {32'h0000_0C02, 32'h0000_0C01, 32'h0000_0C00};
    @(negedge clk);
    n_vec++; if (in_ready3 !== 3'b000) begin n_err++; $display("FAIL three_oor_rdy got=%b exp=000", in_ready3); end
    step();
    @(negedge clk);
    n_vec++; if (out_valid3 !== 1'b0) begin n_err++; $display("FAIL three_oor_vld got=%b exp=0", out_valid3); end
    sel3 = 2'd1;
    @(negedge clk);
    n_vec++; if (in_ready3 !== 3'b010) begin n_err++; $display("FAIL three_rdy got=%b exp=010", in_ready3); end
    step();
    in_valid3 = '0;
    @(negedge clk);
    n_vec++; if (out_valid3 !== 1'b1 || out_data3 !== 32'h0C01 || out_sel3 !== 2'd1) begin
      n_err++; $display("FAIL three_out got=%b/%h/%0d exp=1/c01/1", out_valid3, out_data3, out_sel3);
    end
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      sel = 2'($urandom_range(0, 3));
      in_valid = 4'($urandom);
      for (int k = 0; k < N; k++) set_ch(k, $urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      n_vec++; if (in_ready !== exp_rdy()) begin n_err++; $display("FAIL rand_rdy c=%0d got=%b exp=%b", c, in_ready, exp_rdy()); end
      n_vec++; if (out_valid !== (q.size() != 0)) begin n_err++; $display("FAIL rand_vld c=%0d got=%b exp=%b", c, out_valid, q.size() != 0); end
      if (q.size() != 0) begin
        n_vec++;
        if (out_data !== q[0].d || out_sel !== q[0].s) begin
          n_err++; $display("FAIL rand_out c=%0d got=%h/%0d exp=%h/%0d", c, out_data, out_sel, q[0].d, q[0].s);
        end
      end
      step();
    end
    flush = 1'b0; in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_three();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
